// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the digit-serial adder.
// Optional subtract support is enabled with SERIAL_ADDER_SUB_EN (see serial_adder_n).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int DIGIT_DEF = 1;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/serial_adder_n_fa_digit.sv
// Combinational DIGIT-bit ripple adder built from bit-level full adders.
// c_msb is the carry into the top bit, used by the parent for overflow detection.
module fa_digit
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    assign carry[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign {carry[gi+1], s[gi]} = full_add(x[gi], y[gi], carry[gi]);
        end
    endgenerate

    assign co    = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder: WIDTH-bit operands consumed DIGIT bits per cycle, LSB digit first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b computed as a + ~b + 1).
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_adder_n: WIDTH must be 2..64 and a multiple of DIGIT");
        end
    endgenerate

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   b_cap;
    logic               c_cap;
    logic [DIGIT-1:0]   dig_s;
    logic               dig_co;
    logic               dig_cmsb;
    logic [WIDTH-1:0]   sum_d;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract inverts b and forces the carry-in to 1; cin only matters when adding.
    assign b_cap = b ^ {WIDTH{sub}};
    assign c_cap = sub | cin;
`else
    assign b_cap = b;
    assign c_cap = cin;
`endif

    fa_digit #(
        .DIGIT (DIGIT)
    ) u_fa_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    generate
        if (DIGIT == WIDTH) begin : g_sum_whole
            assign sum_d = dig_s;
        end else begin : g_sum_shift
            assign sum_d = {dig_s, sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_cap;
                        carry_q <= c_cap;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_d;
                    carry_q <= dig_co;
                    // The last digit holds bit WIDTH-1, so its carries define cout/ovf.
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        cout_q  <= dig_co;
                        ovf_q   <= dig_co ^ dig_cmsb;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance.
// Subtract steps run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_n;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

`ifdef SERIAL_ADDER_SUB_EN
    logic        sub8 = 1'b0;
    logic        sub16 = 1'b0;
`endif

    logic        sel16 = 1'b0;
    logic        obs_done, obs_busy, obs_cout, obs_ovf;
    logic [15:0] obs_sum;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign obs_done = sel16 ? done16 : done8;
    assign obs_busy = sel16 ? busy16 : busy8;
    assign obs_cout = sel16 ? cout16 : cout8;
    assign obs_ovf  = sel16 ? ovf16  : ovf8;
    assign obs_sum  = sel16 ? sum16  : {8'h00, sum8};

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    // Reference: plain wide addition; overflow from operand/result sign bits.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic cv, input logic sv);
        logic [16:0] mask, bb, full;
        logic        cc;
        exp_t        r;
        mask   = (17'd1 << w) - 17'd1;
        bb     = sv ? ({1'b0, ~bv} & mask) : ({1'b0, bv} & mask);
        cc     = sv ? 1'b1 : cv;
        full   = ({1'b0, av} & mask) + bb + {16'd0, cc};
        r.sum  = full[15:0] & mask[15:0];
        r.cout = full[w];
        r.ovf  = (av[w-1] == bb[w-1]) && (r.sum[w-1] != av[w-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input logic st);
        if (w == 8) begin
            a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = st;
`ifdef SERIAL_ADDER_SUB_EN
            sub8 = sv;
`endif
        end else begin
            a16 = av; b16 = bv; cin16 = cv; start16 = st;
`ifdef SERIAL_ADDER_SUB_EN
            sub16 = sv;
`endif
        end
        if (sv) begin end
    endtask

    // One operation: start for one cycle, scramble inputs after capture, wait for done.
    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv);
        exp_t e;
        int   cyc;
        int   n;
        bit   seen;
        n     = (w == 8) ? 8 : 4;
        sel16 = (w == 16);
        sb.push_back(model(w, av, bv, cv, sv));
        @(negedge clk);
        drive(w, av, bv, cv, sv, 1'b1);
        @(negedge clk);
        drive(w, ~av, ~bv, ~cv, ~sv, 1'b0);
        check("busy_in_run", obs_busy, 1);
        cyc  = 1;
        seen = 0;
        while (cyc <= 40) begin
            if (obs_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            check("latency", cyc, n + 1);
            check("sum", obs_sum, e.sum);
            check("cout", obs_cout, e.cout);
            check("ovf", obs_ovf, e.ovf);
            $display("[TB] w=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d cyc=%0d",
                     w, av, bv, cv, sv, obs_sum, obs_cout, obs_ovf, cyc);
            @(negedge clk);
            check("done_one_cycle", obs_done, 0);
            check("busy_idle", obs_busy, 0);
            check("sum_hold", obs_sum, e.sum);
        end
    endtask

    initial begin
        exp_t e;
        int   ndone;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_ovf", ovf8, 0);
        check("rst_busy16", busy16, 0);
        rst_n = 1'b1;

        // Directed additions
        run_op(8, 16'h000F, 16'h0001, 1'b0, 1'b0);
        run_op(8, 16'h007F, 16'h0001, 1'b0, 1'b0);
        run_op(8, 16'h00FF, 16'h0001, 1'b1, 1'b0);
        run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'b0);
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Start held high for 20 cycles: two operations, start in done cycle ignored
        sel16 = 1'b0;
        e = model(8, 16'h0012, 16'h0034, 1'b0, 1'b0);
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        drive(8, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b1);
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 20) start8 = 1'b0;
            if (done8) begin
                ndone++;
                check("hold_done_cycle", i, (ndone == 1) ? 9 : 19);
                e = sb.pop_front();
                check("hold_sum", sum8, e.sum);
                $display("[TB] held start: done #%0d at cycle %0d sum=%h", ndone, i, sum8);
            end
            if (i == 10) check("hold_idle_after_done", busy8, 0);
        end
        check("hold_done_count", ndone, 2);

        // Reset in RUN cycle 3 aborts without done
        @(negedge clk);
        drive(8, 16'h0055, 16'h0011, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_sum", sum8, 0);
        check("abort_done", done8, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", ndone, 0);
        rst_n = 1'b1;
        $display("[TB] reset mid-run: busy=%0d sum=%h", busy8, sum8);
        run_op(8, 16'h003C, 16'h0042, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8, 16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(8, 16'h0080, 16'h0001, 1'b0, 1'b1);
        run_op(16, 16'h1234, 16'h1234, 1'b0, 1'b1);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter DIGIT, default 1: bits added per cycle; WIDTH % DIGIT == 0 is required, otherwise elaboration fails.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands; captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in; captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result; holds its value until the next accepted start.
REQ-011 The block SHALL have ports cout and ovf, output, 1 bit each: final carry-out and two's-complement overflow; both hold with sum.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 SHALL capture a, b and cin into shift registers, clear the digit counter, and move to RUN on the next edge.
REQ-014 Each RUN cycle SHALL add the low DIGIT bits of both operand registers plus the carry register, shift the result digit into sum from the MSB side, shift the operands right by DIGIT, and register the digit carry.
REQ-015 After WIDTH/DIGIT RUN cycles the FSM SHALL move to DONE; done SHALL be high for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be WIDTH/DIGIT+1 cycles from the edge that accepts start to the cycle in which done is high.
REQ-017 cout SHALL be the carry out of bit WIDTH-1.
REQ-018 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 start asserted in RUN or DONE SHALL be ignored: no restart and no queuing.
REQ-020 A start asserted in the done cycle SHALL be ignored; start is accepted only once the FSM is back in IDLE.
REQ-021 Changes to a, b or cin after capture SHALL NOT affect the operation in progress.
REQ-022 sum, cout and ovf SHALL change only during RUN and SHALL remain stable in IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, with busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0 and counter=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation without asserting done; the first start after reset release SHALL behave as from power-up.

Configuration
REQ-025 With SERIAL_ADDER_SUB_EN defined, the block SHALL add input sub (1 bit, captured on start); sub=1 SHALL compute a - b as a + ~b + 1, with cin ignored, and cout=1 then meaning no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default constants WIDTH_DEF=8 and DIGIT_DEF=1.
REQ-028 The design SHALL use one sub-module, fa_digit: a combinational DIGIT-bit ripple adder built from bit-level full adders, with inputs x[DIGIT], y[DIGIT], ci and outputs s[DIGIT], co, and c_msb (the carry into its top bit, for ovf).

Verification
REQ-029 The bench SHALL cover: WIDTH=8, DIGIT=1, a=0x0F, b=0x01, cin=0, start -> done at cycle 9, sum=0x10, cout=0, ovf=0.
REQ-030 The bench SHALL cover: WIDTH=8, a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; then a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-031 The bench SHALL cover: WIDTH=16, DIGIT=4, a=0xFFFF, b=0x0001 -> done at cycle 5, sum=0x0000, cout=1.
REQ-032 The bench SHALL cover: start held high for 20 cycles -> exactly one done per 10-cycle operation (DIGIT=1, WIDTH=8), and start in the done cycle ignored.
REQ-033 The bench SHALL cover: rst_n pulsed low at RUN cycle 3 -> busy=0 and sum=0 immediately, no done pulse; the next start gives a correct result.
REQ-034 The bench SHALL cover, with SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
